// File: rtl/qfmt_pkg.sv
// Shared Q-format definitions for the divide path: default word geometry,
// divider FSM states and derived sizes.
package qfmt_pkg;
  localparam int QFMT_Q = 15;
  localparam int QFMT_N = 32;
  localparam int MAG_W  = QFMT_N - 1;
  localparam int ITER   = QFMT_N + QFMT_Q - 1;
  localparam int CNT_W  = $clog2(ITER + 1);
  localparam logic [MAG_W-1:0] SAT_MAG = {MAG_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/qdiv_seq_if.sv
// Operand/result bundle between a divide requester and qdiv_seq.
interface qdiv_seq_if #(
  parameter int N = qfmt_pkg::QFMT_N
);
  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic [N-1:0] o_quotient;
  logic         o_busy;
  logic         o_complete;
  logic         o_overflow;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_quotient, o_busy, o_complete, o_overflow
  );
  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_quotient, o_busy, o_complete, o_overflow
  );
endinterface

// File: rtl/qdiv_step.sv
// One restoring divide step: shift in a dividend bit, subtract the divisor
// by two's-complement add, keep the difference only when it stays non-negative.
module qdiv_step
  import qfmt_pkg::*;
#(
  parameter int N = QFMT_N
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_bit,
  input  logic [N-2:0] i_div,
  output logic [N-1:0] o_rem,
  output logic         o_qbit
);
  logic [N-1:0] w_shift;
  logic [N-1:0] w_neg;
  logic [N-1:0] w_trial;
  // The held remainder is always below the divisor, so its MSB never matters.
  logic         w_unused_msb;

  assign w_unused_msb = i_rem[N-1];
  assign w_shift = {i_rem[N-2:0], i_bit};
  assign w_neg   = ~{1'b0, i_div} + {{(N-1){1'b0}}, 1'b1};
  assign w_trial = w_shift + w_neg;
  assign o_qbit  = ~w_trial[N-1];
  assign o_rem   = o_qbit ? w_trial : w_shift;
endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed-magnitude Q-format divider: one quotient bit per clock,
// saturating on magnitude overflow and divide-by-zero.
module qdiv_seq
  import qfmt_pkg::*;
#(
  parameter int Q = QFMT_Q,
  parameter int N = QFMT_N
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  qdiv_seq_if.slave  bus
);
  localparam int MW   = N - 1;
  localparam int DW   = N - 1 + Q;
  localparam int LAST = N + Q - 1;
  localparam int CW   = $clog2(LAST + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_dvd;
  logic [DW-1:0]   r_quo;
  logic [MW-1:0]   r_dvs;
  logic [N-1:0]    r_rem;
  logic            r_sign;
  logic [N-1:0]    r_quotient;
  logic            r_busy;
  logic            r_complete;
  logic            r_overflow;

  logic [N-1:0]    w_rem_nxt;
  logic            w_qbit;
  logic            w_ov;
  logic [MW-1:0]   w_mag;
  logic [N-1:0]    w_result;

  qdiv_step #(.N(N)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[DW-1]),
    .i_div  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Zero divisor leaves garbage in r_quo; it is masked by saturation here.
  assign w_ov     = (|r_quo[DW-1:MW]) | ~(|r_dvs);
  assign w_mag    = w_ov ? {MW{1'b1}} : r_quo[MW-1:0];
  assign w_result = {r_sign & (|w_mag), w_mag};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_sign     <= 1'b0;
      r_quotient <= '0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_complete <= 1'b0;
          if (bus.i_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_dvd   <= {bus.i_dividend[N-2:0], {Q{1'b0}}};
            r_dvs   <= bus.i_divisor[N-2:0];
            r_sign  <= bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (r_cnt == CW'(LAST)) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_complete <= 1'b1;
            r_quotient <= w_result;
            r_overflow <= w_ov;
          end else begin
            r_rem <= w_rem_nxt;
            r_dvd <= r_dvd << 1;
            r_quo <= {r_quo[DW-2:0], w_qbit};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_quotient = r_quotient;
  assign bus.o_busy     = r_busy;
  assign bus.o_complete = r_complete;
  assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_qdiv_seq.sv
// Directed bench for qdiv_seq: Q15 divides, saturation, start handling, reset abort.
module tb_qdiv_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  qdiv_seq_if #(.N(32)) bus ();
  qdiv_seq #(.Q(15), .N(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.o_complete !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic divide(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic exp_ov);
    int n;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check({tag, ".busy"}, 32'(bus.o_busy), 32'd1);
    wait_done(n);
    check({tag, ".lat"}, 32'(n), 32'd47);
    check({tag, ".q"}, bus.o_quotient, exp_q);
    check({tag, ".ov"}, 32'(bus.o_overflow), 32'(exp_ov));
    tick();
    check({tag, ".pulse"}, 32'(bus.o_complete), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    tick();
    tick();
    check("rst.q", bus.o_quotient, 32'h0);
    check("rst.busy", 32'(bus.o_busy), 32'd0);
    check("rst.cmp", 32'(bus.o_complete), 32'd0);
    check("rst.ov", 32'(bus.o_overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    divide("p3_p2", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0);
    divide("n3_p2", 32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0);
    divide("z_n2", 32'h0000_0000, 32'h8001_0000, 32'h0000_0000, 1'b0);
    divide("p1_p3", 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0);
    divide("div0", 32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

    // start pulsed with new operands 20 cycles into RUN must be ignored
    bus.i_dividend = 32'h0001_8000;
    bus.i_divisor  = 32'h0001_0000;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (19) tick();
    bus.i_dividend = 32'h0000_8000;
    bus.i_divisor  = 32'h0001_8000;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_done(n);
    check("ign.lat", 32'(n), 32'd27);
    check("ign.q", bus.o_quotient, 32'h0000_C000);
    tick();
    check("ign.busy", 32'(bus.o_busy), 32'd0);

    // start held high through DONE gives a back-to-back divide
    bus.i_dividend = 32'h0001_8000;
    bus.i_divisor  = 32'h0001_0000;
    bus.i_start    = 1'b1;
    tick();
    bus.i_dividend = 32'h0000_8000;
    bus.i_divisor  = 32'h0001_8000;
    wait_done(n);
    check("b2b.lat1", 32'(n), 32'd47);
    check("b2b.q1", bus.o_quotient, 32'h0000_C000);
    tick();
    bus.i_start = 1'b0;
    check("b2b.cmp", 32'(bus.o_complete), 32'd0);
    check("b2b.busy", 32'(bus.o_busy), 32'd1);
    check("b2b.hold", bus.o_quotient, 32'h0000_C000);
    wait_done(n);
    check("b2b.lat2", 32'(n), 32'd47);
    check("b2b.q2", bus.o_quotient, 32'h0000_2AAA);
    tick();

    divide("sat", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);

    // reset 30 cycles into RUN aborts with no completion
    bus.i_dividend = 32'h0000_8000;
    bus.i_divisor  = 32'h0001_8000;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (29) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abrt.q", bus.o_quotient, 32'h0);
    check("abrt.busy", 32'(bus.o_busy), 32'd0);
    check("abrt.cmp", 32'(bus.o_complete), 32'd0);
    check("abrt.ov", 32'(bus.o_overflow), 32'd0);
    seen = 0;
    repeat (60) begin
      tick();
      if (bus.o_complete === 1'b1) seen++;
    end
    check("abrt.nocmp", 32'(seen), 32'd0);

    divide("post", 32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/qdiv_seq.md
# qdiv_seq

Sequential signed-magnitude fixed-point divider for the Q-format arithmetic datapath (default Q15 in a 32-bit word: bit N-1 is sign, bits N-2:0 are magnitude). It computes one quotient bit per clock with a restoring shift-subtract loop. Each subtraction is carried out by adding the two's complement of the divisor magnitude. It accepts operands on a start strobe and returns a saturated, sign-corrected quotient with a one-cycle completion pulse. It sits downstream of the negation/two's-complement helper in the divide path.

## Interface
- Q, 15, number of fractional bits
- N, 32, total word width including sign bit
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, synchronous and active-low; single clock domain
- i_start  in  1  operand-valid strobe; sampled only in IDLE or DONE
- i_dividend  in  N  signed-magnitude dividend
- i_divisor  in  N  signed-magnitude divisor
- o_quotient  out  N  signed-magnitude quotient; held until the next accepted start
- o_busy  out  1  high in RUN
- o_complete  out  1  one-cycle pulse when o_quotient is valid
- o_overflow  out  1  quotient saturated (magnitude overflow or divide-by-zero); held with o_quotient

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on i_start.
  - RUN→DONE when the iteration counter reaches N+Q-1.
  - DONE→IDLE after one cycle.
  - DONE with i_start high goes directly to RUN.
- Start capture:
  - Latch dividend magnitude zero-extended and shifted left by Q into an (N-1+Q)-bit working register.
  - Latch divisor magnitude (N-1 bits).
  - Latch sign = i_dividend[N-1] XOR i_divisor[N-1].
  - Clear partial remainder (N bits), quotient shift register ((N-1+Q) bits) and counter.
- Each RUN cycle:
  - Shift the next dividend MSB into the remainder.
  - Compute trial = remainder + (~{1'b0,divisor} + 1), N bits wide.
  - If trial is non-negative (MSB 0), keep trial and shift in quotient bit 1; else keep the remainder and shift in 0.
- Result:
  - Low N-1 bits of the quotient register form the magnitude.
  - Any set bit above N-2 → o_overflow=1 and magnitude = all ones.
  - Divisor magnitude zero → o_overflow=1 and magnitude = all ones, with the same latency as a normal divide.
- Sign:
  - Output sign = latched sign, except a zero magnitude forces sign 0 (no negative zero).
  - Dividend magnitude zero with nonzero divisor → 0x0000_0000, no overflow.
- i_start during RUN is ignored; operands are not re-sampled.
- Truncation toward zero; no rounding.

## Timing
- Reset (i_rst_n low at a rising edge):
  - State IDLE.
  - o_quotient=0, o_busy=0, o_complete=0, o_overflow=0.
  - Counter and working registers cleared.
  - Reset has priority over everything and aborts RUN with no o_complete.
- Start sampled at edge k:
  - o_busy high from cycle k+1 through k+N+Q-1.
  - o_quotient, o_overflow and o_complete (pulse) updated at edge k+N+Q.
  - Latency is N+Q = 47 clocks with defaults.
- o_complete is high for exactly one cycle. It is low in every other state, including back-to-back starts.
- Back-to-back operation: i_start high during the DONE cycle is accepted. o_quotient keeps the previous result until the new completion edge.
- Throughput: one divide per N+Q clocks.

## Structure
- Shared package (qfmt_pkg):
  - Q and N defaults.
  - State enum {IDLE, RUN, DONE}.
  - Localparams: MAG_W = N-1, ITER = N+Q-1, counter width = $clog2(ITER+1).
  - Saturation constant {MAG_W{1'b1}}.
- One sub-module, qdiv_step: combinational single restoring step.
  - Inputs: remainder, incoming bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - The two's-complement add lives inside it.
- Top level holds the FSM, counter, shift registers, saturation and sign logic.

## Test plan
- 3.0 / 2.0: 0x0001_8000 / 0x0001_0000 → after 47 clocks o_quotient=0x0000_C000, o_overflow=0, one o_complete pulse.
- Signs: -3.0 / 2.0 = 0x8001_8000 / 0x0001_0000 → 0x8000_C000. 0x0000_0000 / 0x8001_0000 → 0x0000_0000 (sign cleared).
- 1.0 / 3.0: 0x0000_8000 / 0x0001_8000 → 0x0000_2AAA (truncated).
- Saturation:
  - 0x7FFF_FFFF / 0x0000_0001 → 0x7FFF_FFFF, o_overflow=1.
  - 0x8000_8000 / 0x0000_0000 → 0xFFFF_FFFF, o_overflow=1, latency still 47.
- Control:
  - i_start pulsed with new operands at cycle 20 of RUN → ignored, first result unchanged.
  - i_start held high through DONE → second result 47 clocks after the DONE edge.
- Reset: i_rst_n low at cycle 30 of RUN → next cycle IDLE, all outputs 0, no o_complete. A following divide is correct.
